// File: rtl/pa_sysmap_cfg.sv
// pa_sysmap_cfg: programmable region table with registered IFU/LSU
// attribute lookups, one-shot strap load and tcipif register access.
module pa_sysmap_cfg #(
    parameter int                   REGION_NUM  = 8,
    parameter int                   ADDR_WIDTH  = 20,
    parameter int                   FLG_WIDTH   = 5,
    parameter logic [FLG_WIDTH-1:0] FLG_DEFAULT = '0
) (
    input  logic                             forever_cpuclk,
    input  logic                             cpurst_b,
    input  logic                             ifu_sysmap_req,
    input  logic [31:0]                      ifu_sysmap_pa,
    input  logic                             lsu_sysmap_req,
    input  logic [31:0]                      lsu_sysmap_pa,
    input  logic                             ifu_sysmap_rst_sample,
    input  logic [REGION_NUM*ADDR_WIDTH-1:0] pad_cpu_sysmap_base,
    input  logic [REGION_NUM*FLG_WIDTH-1:0]  pad_cpu_sysmap_flg,
    input  logic                             tcipif_sysmap_sel,
    input  logic                             tcipif_sysmap_write,
    input  logic [15:0]                      tcipif_sysmap_addr,
    input  logic [31:0]                      tcipif_sysmap_wdata,
    output logic                             sysmap_ifu_vld,
    output logic [FLG_WIDTH-1:0]             sysmap_ifu_flg,
    output logic                             sysmap_lsu_vld,
    output logic [FLG_WIDTH-1:0]             sysmap_lsu_flg,
    output logic                             sysmap_tcipif_cmplt,
    output logic [31:0]                      sysmap_tcipif_rdata,
    output logic                             sysmap_tcipif_err
);

    localparam int          IDXW  = (REGION_NUM > 1) ? $clog2(REGION_NUM) : 1;
    localparam logic [15:0] LIMIT = 16'(8 * REGION_NUM);

    typedef enum logic {
        ST_UNLOADED,
        ST_LOADED
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_load;

    logic [ADDR_WIDTH-1:0] r_base [REGION_NUM];
    logic [FLG_WIDTH-1:0]  r_flg  [REGION_NUM];
    logic [REGION_NUM-1:0] r_lock;

    logic                  r_ifu_vld;
    logic [FLG_WIDTH-1:0]  r_ifu_flg;
    logic                  r_lsu_vld;
    logic [FLG_WIDTH-1:0]  r_lsu_flg;
    logic                  r_cmplt;
    logic [31:0]           r_rdata;
    logic                  r_err;

    logic                  w_in_range;
    logic [IDXW-1:0]       w_idx;
    logic                  w_is_flg;
    logic                  w_wr_allow;
    logic                  w_wr_en;
    logic                  w_err;
    logic [31:0]           w_rd;
    logic [ADDR_WIDTH-1:0] w_ifu_hi;
    logic [ADDR_WIDTH-1:0] w_lsu_hi;
    logic [FLG_WIDTH-1:0]  w_ifu_flg;
    logic [FLG_WIDTH-1:0]  w_lsu_flg;
    logic                  w_unused;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state <= ST_UNLOADED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_UNLOADED: begin
                if (ifu_sysmap_rst_sample) begin
                    w_state_nxt = ST_LOADED;
                    w_load      = 1'b1;
                end
            end
            ST_LOADED: begin
                w_state_nxt = ST_LOADED;
            end
        endcase
    end

    assign w_in_range = (tcipif_sysmap_addr < LIMIT)
                      && (tcipif_sysmap_addr[1:0] == 2'b00);
    assign w_idx      = tcipif_sysmap_addr[3 +: IDXW];
    assign w_is_flg   = tcipif_sysmap_addr[2];
    assign w_wr_allow = w_in_range && (r_state == ST_LOADED) && !r_lock[w_idx];
    assign w_wr_en    = tcipif_sysmap_sel && tcipif_sysmap_write && w_wr_allow;
    assign w_err      = tcipif_sysmap_write ? !w_wr_allow : !w_in_range;

    always_comb begin
        w_rd = '0;
        if (w_is_flg) begin
            w_rd[FLG_WIDTH-1:0] = r_flg[w_idx];
            w_rd[31]            = r_lock[w_idx];
        end else begin
            w_rd[31 -: ADDR_WIDTH] = r_base[w_idx];
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            for (int i = 0; i < REGION_NUM; i++) begin
                r_base[i] <= '0;
                r_flg[i]  <= FLG_DEFAULT;
            end
            r_lock <= '0;
        end else if (w_load) begin
            for (int i = 0; i < REGION_NUM; i++) begin
                r_base[i] <= pad_cpu_sysmap_base[i*ADDR_WIDTH +: ADDR_WIDTH];
                r_flg[i]  <= pad_cpu_sysmap_flg[i*FLG_WIDTH +: FLG_WIDTH];
            end
            r_lock <= '0;
        end else if (w_wr_en) begin
            if (w_is_flg) begin
                r_flg[w_idx]  <= tcipif_sysmap_wdata[FLG_WIDTH-1:0];
                // only reachable while unlocked, so the lock is set-only
                r_lock[w_idx] <= tcipif_sysmap_wdata[31];
            end else begin
                r_base[w_idx] <= tcipif_sysmap_wdata[31 -: ADDR_WIDTH];
            end
        end
    end

    assign w_ifu_hi = ifu_sysmap_pa[31 -: ADDR_WIDTH];
    assign w_lsu_hi = lsu_sysmap_pa[31 -: ADDR_WIDTH];

    // scan from the top so the lowest matching region wins
    always_comb begin
        w_ifu_flg = FLG_DEFAULT;
        w_lsu_flg = FLG_DEFAULT;
        for (int i = REGION_NUM - 1; i >= 0; i--) begin
            if (w_ifu_hi < r_base[i]) begin
                w_ifu_flg = r_flg[i];
            end
            if (w_lsu_hi < r_base[i]) begin
                w_lsu_flg = r_flg[i];
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_ifu_vld <= 1'b0;
            r_ifu_flg <= '0;
            r_lsu_vld <= 1'b0;
            r_lsu_flg <= '0;
            r_cmplt   <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_ifu_vld <= ifu_sysmap_req;
            if (ifu_sysmap_req) begin
                r_ifu_flg <= w_ifu_flg;
            end
            r_lsu_vld <= lsu_sysmap_req;
            if (lsu_sysmap_req) begin
                r_lsu_flg <= w_lsu_flg;
            end
            r_cmplt <= tcipif_sysmap_sel;
            r_err   <= tcipif_sysmap_sel && w_err;
            r_rdata <= (tcipif_sysmap_sel && !tcipif_sysmap_write && w_in_range)
                       ? w_rd : '0;
        end
    end

    assign sysmap_ifu_vld      = r_ifu_vld;
    assign sysmap_ifu_flg      = r_ifu_flg;
    assign sysmap_lsu_vld      = r_lsu_vld;
    assign sysmap_lsu_flg      = r_lsu_flg;
    assign sysmap_tcipif_cmplt = r_cmplt;
    assign sysmap_tcipif_rdata = r_rdata;
    assign sysmap_tcipif_err   = r_err;

    assign w_unused = ^{ifu_sysmap_pa, lsu_sysmap_pa, tcipif_sysmap_wdata};

endmodule

// File: tb/tb_pa_sysmap_cfg.sv
// Bench for pa_sysmap_cfg: directed vector table plus randomized traffic
// checked against a region-table reference model.
module tb_pa_sysmap_cfg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_b;
    logic        ireq, lreq, samp, sel, wr;
    logic [31:0] ipa, lpa, wdata;
    logic [15:0] addr;
    logic [159:0] pad_base;
    logic [39:0]  pad_flg;
    logic        ivld, lvld, cmplt, err;
    logic [4:0]  iflg, lflg;
    logic [31:0] rdata;

    pa_sysmap_cfg dut (
        .forever_cpuclk       (clk),
        .cpurst_b             (rst_b),
        .ifu_sysmap_req       (ireq),
        .ifu_sysmap_pa        (ipa),
        .lsu_sysmap_req       (lreq),
        .lsu_sysmap_pa        (lpa),
        .ifu_sysmap_rst_sample(samp),
        .pad_cpu_sysmap_base  (pad_base),
        .pad_cpu_sysmap_flg   (pad_flg),
        .tcipif_sysmap_sel    (sel),
        .tcipif_sysmap_write  (wr),
        .tcipif_sysmap_addr   (addr),
        .tcipif_sysmap_wdata  (wdata),
        .sysmap_ifu_vld       (ivld),
        .sysmap_ifu_flg       (iflg),
        .sysmap_lsu_vld       (lvld),
        .sysmap_lsu_flg       (lflg),
        .sysmap_tcipif_cmplt  (cmplt),
        .sysmap_tcipif_rdata  (rdata),
        .sysmap_tcipif_err    (err)
    );

    int checks;
    int fails;

    // strap values and reference model state
    logic [19:0] sb [8];
    logic [4:0]  sf [8];
    logic [19:0] mb [8];
    logic [4:0]  mf [8];
    bit          ml [8];
    bit          mld;

    logic        e_ivld, e_lvld, e_cmplt, e_err;
    logic [4:0]  e_iflg, e_lflg;
    logic [31:0] e_rdata;

    typedef struct {
        bit          sel;
        bit          wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        bit          samp;
        bit          ireq;
        logic [31:0] ipa;
        bit          lreq;
        logic [31:0] lpa;
        logic [4:0]  xif;
        logic [4:0]  xlf;
        bit          xcm;
        logic [31:0] xrd;
        bit          xer;
    } vec_t;

    vec_t tv [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic pack_straps();
        for (int i = 0; i < 8; i++) begin
            pad_base[i*20 +: 20] = sb[i];
            pad_flg[i*5 +: 5]    = sf[i];
        end
    endtask

    function automatic logic [4:0] lookup(input logic [31:0] pa);
        int unsigned hi;
        hi = pa / 4096;
        for (int i = 0; i < 8; i++) begin
            if (hi < int'(mb[i])) return mf[i];
        end
        return 5'd0;
    endfunction

    function automatic logic [31:0] regrd(input int unsigned off);
        int unsigned i;
        i = off / 8;
        if (off % 8 == 0) return {mb[i], 12'h000};
        return {ml[i], 26'd0, mf[i]};
    endfunction

    // model the effect of the inputs currently applied for one cycle
    task automatic predict();
        bit          inr;
        bit          ok;
        int unsigned off;
        int unsigned ri;
        if (!rst_b) begin
            mld = 0;
            for (int i = 0; i < 8; i++) begin
                mb[i] = '0;
                mf[i] = '0;
                ml[i] = 0;
            end
            {e_ivld, e_lvld, e_cmplt, e_err} = '0;
            e_iflg  = '0;
            e_lflg  = '0;
            e_rdata = '0;
            return;
        end
        e_ivld = ireq;
        if (ireq) e_iflg = lookup(ipa);
        e_lvld = lreq;
        if (lreq) e_lflg = lookup(lpa);
        e_cmplt = sel;
        e_rdata = '0;
        e_err   = 1'b0;
        if (sel) begin
            off = addr;
            inr = (off < 64) && (off % 4 == 0);
            ri  = inr ? off / 8 : 0;
            if (!wr) begin
                e_err = !inr;
                if (inr) e_rdata = regrd(off);
            end else begin
                ok    = inr && mld && !ml[ri];
                e_err = !ok;
                if (ok) begin
                    if (off % 8 == 0) begin
                        mb[ri] = wdata[31:12];
                    end else begin
                        mf[ri] = wdata[4:0];
                        if (wdata[31]) ml[ri] = 1;
                    end
                end
            end
        end
        if (!mld && samp) begin
            mld = 1;
            for (int i = 0; i < 8; i++) begin
                mb[i] = sb[i];
                mf[i] = sf[i];
                ml[i] = 0;
            end
        end
    endtask

    task automatic tick();
        predict();
        @(posedge clk);
        #1;
        chk("ifu_vld", ivld, e_ivld);
        chk("ifu_flg", iflg, e_iflg);
        chk("lsu_vld", lvld, e_lvld);
        chk("lsu_flg", lflg, e_lflg);
        chk("cmplt", cmplt, e_cmplt);
        chk("rdata", rdata, e_rdata);
        chk("err", err, e_err);
    endtask

    task automatic apply(input vec_t v);
        sel   = v.sel;
        wr    = v.wr;
        addr  = v.addr;
        wdata = v.wdata;
        samp  = v.samp;
        ireq  = v.ireq;
        ipa   = v.ipa;
        lreq  = v.lreq;
        lpa   = v.lpa;
    endtask

    function automatic logic [31:0] genpa();
        logic [19:0] h;
        int unsigned k;
        if ($urandom_range(0, 1) == 0) return $urandom;
        k = $urandom_range(0, 7);
        h = mb[k] + 20'($urandom_range(0, 2)) - 20'd1;
        return {h, 12'($urandom)};
    endfunction

    initial begin
        checks = 0;
        fails  = 0;
        rst_b = 1'b0;
        {ireq, lreq, samp, sel, wr} = '0;
        ipa = '0; lpa = '0; wdata = '0; addr = '0;
        for (int i = 0; i < 8; i++) begin
            sb[i] = 20'((i + 1) * 16);
            sf[i] = 5'(i + 1);
        end
        pack_straps();

        tv[0]  = '{1'b0,1'b0,16'h00,32'h0,1'b0, 1'b1,32'h0,1'b1,32'h00010000, 5'd1,5'd2,1'b0,32'h0,1'b0};
        tv[1]  = '{1'b0,1'b0,16'h00,32'h0,1'b0, 1'b1,32'hFFFFF000,1'b1,32'h0007F000, 5'd0,5'd8,1'b0,32'h0,1'b0};
        tv[2]  = '{1'b1,1'b1,16'h18,32'h00080000,1'b0, 1'b1,32'h0007F000,1'b0,32'h0, 5'd8,5'd8,1'b1,32'h0,1'b0};
        tv[3]  = '{1'b1,1'b0,16'h18,32'h0,1'b0, 1'b1,32'h0007F000,1'b1,32'h00035000, 5'd4,5'd4,1'b1,32'h00080000,1'b0};
        tv[4]  = '{1'b1,1'b1,16'h14,32'h80000011,1'b0, 1'b0,32'h0,1'b0,32'h0, 5'd4,5'd4,1'b1,32'h0,1'b0};
        tv[5]  = '{1'b1,1'b0,16'h14,32'h0,1'b0, 1'b1,32'h00025000,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h80000011,1'b0};
        tv[6]  = '{1'b1,1'b1,16'h14,32'h0000001F,1'b0, 1'b1,32'h00025000,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h0,1'b1};
        tv[7]  = '{1'b1,1'b0,16'h14,32'h0,1'b0, 1'b1,32'h00025000,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h80000011,1'b0};
        tv[8]  = '{1'b1,1'b1,16'h10,32'hFFFFF000,1'b0, 1'b0,32'h0,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h0,1'b1};
        tv[9]  = '{1'b1,1'b0,16'h10,32'h0,1'b0, 1'b0,32'h0,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h00030000,1'b0};
        tv[10] = '{1'b1,1'b0,16'h40,32'h0,1'b0, 1'b0,32'h0,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h0,1'b1};
        tv[11] = '{1'b1,1'b0,16'h06,32'h0,1'b0, 1'b0,32'h0,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h0,1'b1};
        tv[12] = '{1'b1,1'b1,16'h41,32'h5,1'b0, 1'b0,32'h0,1'b0,32'h0, 5'h11,5'd4,1'b1,32'h0,1'b1};
        tv[13] = '{1'b1,1'b0,16'h18,32'h0,1'b1, 1'b1,32'h0007F000,1'b0,32'h0, 5'd4,5'd4,1'b1,32'h00080000,1'b0};
        tv[14] = '{1'b1,1'b0,16'h1C,32'h0,1'b0, 1'b1,32'h0003F000,1'b1,32'hFFFFF000, 5'd4,5'd0,1'b1,32'h00000004,1'b0};
        tv[15] = '{1'b0,1'b0,16'h00,32'h0,1'b0, 1'b0,32'h0,1'b0,32'h0, 5'd4,5'd0,1'b0,32'h0,1'b0};

        tick();
        tick();
        chk("rst_cmplt", cmplt, 0);
        chk("rst_ivld", ivld, 0);
        rst_b = 1'b1;

        sel = 1'b1; wr = 1'b1; addr = 16'h0; wdata = 32'h12345000;
        tick();
        chk("unl_wr_err", err, 1);
        wr = 1'b0;
        tick();
        chk("unl_rd_data", rdata, 0);
        chk("unl_rd_err", err, 0);
        wr = 1'b1; addr = 16'h8; wdata = 32'hAAAAA000; samp = 1'b1;
        tick();
        chk("samp_wr_err", err, 1);
        samp = 1'b0; sel = 1'b0; wr = 1'b0;

        for (int k = 0; k < 16; k++) begin
            apply(tv[k]);
            tick();
            chk($sformatf("tbl%0d_iflg", k), iflg, tv[k].xif);
            chk($sformatf("tbl%0d_lflg", k), lflg, tv[k].xlf);
            chk($sformatf("tbl%0d_cmplt", k), cmplt, tv[k].xcm);
            chk($sformatf("tbl%0d_rdata", k), rdata, tv[k].xrd);
            chk($sformatf("tbl%0d_err", k), err, tv[k].xer);
        end

        rst_b = 1'b0; sel = 1'b1; wr = 1'b1; addr = 16'h41;
        ireq = 1'b1; ipa = '0; lreq = 1'b1; lpa = '0; samp = 1'b0;
        tick();
        chk("rmf_ivld", ivld, 0);
        chk("rmf_lvld", lvld, 0);
        chk("rmf_cmplt", cmplt, 0);
        chk("rmf_err", err, 0);
        rst_b = 1'b1; ireq = 1'b0; lreq = 1'b0; wr = 1'b0; addr = 16'h14;
        tick();
        chk("rmf_flg2", rdata, 0);
        addr = 16'h18;
        tick();
        chk("rmf_base3", rdata, 0);
        sel = 1'b0; samp = 1'b1;
        tick();
        samp = 1'b0; sel = 1'b1; wr = 1'b1; addr = 16'h14; wdata = 32'h3;
        tick();
        chk("unlock_wr_err", err, 0);
        sel = 1'b0; wr = 1'b0;

        for (int i = 0; i < 8; i++) begin
            sb[i] = 20'($urandom);
            sf[i] = 5'($urandom);
        end
        pack_straps();

        for (int n = 0; n < 3000; n++) begin
            rst_b = ($urandom_range(0, 299) != 0);
            samp  = ($urandom_range(0, 15) == 0);
            sel   = 1'($urandom_range(0, 1));
            wr    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 8)
                addr = 16'(8 * $urandom_range(0, 7) + 4 * $urandom_range(0, 1));
            else
                addr = 16'($urandom);
            wdata = $urandom;
            if ($urandom_range(0, 7) != 0) wdata[31] = 1'b0;
            ireq = 1'($urandom_range(0, 1));
            ipa  = genpa();
            lreq = 1'($urandom_range(0, 1));
            lpa  = genpa();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/pa_sysmap_cfg.md
# pa_sysmap_cfg

Parametrised system-map unit: holds `REGION_NUM` programmable address regions, each with an upper-bound base address, a memory-attribute flag field and a lock bit. It answers registered attribute lookups for the IFU and LSU physical-address paths. Region registers are loaded from pad straps on a one-shot reset sample and are software-programmable through the tcipif register bus. It sits between the IFU/LSU PA generators and the PMP/bus attribute logic, next to the tcipif slave decoder.

## Interface
Parameters:
- `REGION_NUM`, 8, number of regions; legal range 2..16.
- `ADDR_WIDTH`, 20, compared PA MSBs; region granularity is 2^(32-`ADDR_WIDTH`) bytes.
- `FLG_WIDTH`, 5, attribute flag width; at most 31.
- `FLG_DEFAULT`, 5'b0, flag returned when no region matches, and the reset value of every flag register.

Ports:
- `forever_cpuclk`  in  1  only clock.
- `cpurst_b`  in  1  reset; synchronous and active-low.
- `ifu_sysmap_req`  in  1  IFU lookup valid.
- `ifu_sysmap_pa`  in  32  IFU physical address.
- `lsu_sysmap_req`  in  1  LSU lookup valid.
- `lsu_sysmap_pa`  in  32  LSU physical address.
- `ifu_sysmap_rst_sample`  in  1  one-cycle pulse that loads the pad straps.
- `pad_cpu_sysmap_base`  in  `REGION_NUM`*`ADDR_WIDTH`  strap bases; region i occupies slice [i*`ADDR_WIDTH` +: `ADDR_WIDTH`].
- `pad_cpu_sysmap_flg`  in  `REGION_NUM`*`FLG_WIDTH`  strap flags; same slicing rule.
- `tcipif_sysmap_sel`  in  1  bus access strobe; one cycle per access.
- `tcipif_sysmap_write`  in  1  1 = write, 0 = read.
- `tcipif_sysmap_addr`  in  16  byte offset.
- `tcipif_sysmap_wdata`  in  32  write data.
- `sysmap_ifu_vld`  out  1  IFU result valid.
- `sysmap_ifu_flg`  out  `FLG_WIDTH`  IFU attribute.
- `sysmap_lsu_vld`  out  1  LSU result valid.
- `sysmap_lsu_flg`  out  `FLG_WIDTH`  LSU attribute.
- `sysmap_tcipif_cmplt`  out  1  access complete.
- `sysmap_tcipif_rdata`  out  32  read data.
- `sysmap_tcipif_err`  out  1  access was discarded or out of range; valid with cmplt.

## Operation
Region match:
- Let pa_hi = pa[31:32-`ADDR_WIDTH`].
- The hit region is the lowest index i with pa_hi < base_i (unsigned compare).
- The result is flg_i of the hit region; if no region hits, the result is `FLG_DEFAULT`.
- The IFU and LSU paths are independent, identical comparator trees that read the same register set.

Configuration FSM:
- States are UNLOADED and LOADED. Reset enters UNLOADED.
- UNLOADED -> LOADED when `ifu_sysmap_rst_sample`=1. All bases and flags load from the straps in that cycle and all locks are cleared.
- In LOADED, `ifu_sysmap_rst_sample` is ignored. Only reset leaves LOADED.

Register map:
- Base register i is at offset 8*i. It holds the base in bits [31:32-`ADDR_WIDTH`]; lower bits read 0 and are ignored on write.
- Flag register i is at offset 8*i+4. It holds the flags in bits [`FLG_WIDTH`-1:0] and the lock in bit 31; other bits read 0.
- Offsets at or above 8*`REGION_NUM`, and offsets with addr[1:0]≠0, are out of range. A read returns 0; a write is discarded; err=1 in both cases.

Write rules:
- A write updates the target register only if the state is LOADED and the region is unlocked.
- A write that is discarded because of state or lock gives err=1.
- Writing 1 to lock sets it, and the flags carried in the same write take effect. Writing 0 to lock does not clear it; only reset clears a lock.
- A lock covers both registers of its region.

Simultaneous events:
- `ifu_sysmap_rst_sample` together with a write in UNLOADED: the sample wins, the write is discarded, err=1.
- A lookup issued in the same cycle as a write uses the pre-write values.

## Timing
Reset values (while `cpurst_b`=0 at a clock edge):
- State UNLOADED.
- All bases 0, all flags `FLG_DEFAULT`, all locks 0.
- All outputs 0.

Lookup:
- A request in cycle N gives vld=1 and flg in cycle N+1, registered. Throughput is one lookup per cycle per port.
- When req=0, vld is 0 the next cycle and flg holds its last value.

Bus:
- sel in cycle N gives cmplt=1 in cycle N+1 for exactly one cycle, with rdata and err valid in that cycle.
- rdata is 0 for writes and whenever cmplt=0.
- Back-to-back sel is legal: sel in N and N+1 gives cmplt in N+1 and N+2.
- A write in cycle N is visible to lookups and reads issued in cycle N+1 or later.
- Strap sample in cycle N: lookups issued in N+1 or later see the strap values.

Reset mid-operation:
- A pending cmplt or vld is dropped; outputs are 0 in the cycle after the reset edge.

## Test plan
- Strap load: defaults `REGION_NUM`=8, base_i=(i+1)*0x10000, flg_i=i+1; pulse rst_sample. IFU pa 0x0000_0000 -> flg 1 at N+1. LSU pa 0x0001_0000 -> flg 2. pa 0xFFFF_F000 -> `FLG_DEFAULT`.
- Bus program: write base3 = 0x0008_0000 and read it back -> rdata 0x0008_0000, err 0. A lookup of pa 0x0007_F000 issued the cycle after the write hits the lowest region with pa_hi < base -> region 3 -> flg 4.
- Lock: write flag2 = 0x8000_0011 -> flg2 = 0x11 and locked. Then write flag2 = 0x1F -> err=1 and flg2 stays 0x11. Write base2 -> err=1. Reset -> lock clear.
- UNLOADED guard: write before rst_sample -> err=1, read returns 0. rst_sample in the same cycle as a write -> straps loaded, err=1. A second rst_sample after programming leaves registers unchanged.
- Out of range: read offset 0x40 with 8 regions -> rdata 0, err 1. Back-to-back sel in consecutive cycles -> two consecutive cmplt pulses.
- Reset mid-flight: assert `cpurst_b`=0 in the cycle a lookup and a sel are issued -> vld, cmplt and err are 0 the next cycle, and all registers return to reset values.
